// File: rtl/accumulator_writeback.sv
// Accumulator-to-unified-buffer writeback: sequential row reads, per-lane
// ReLU / rounding shift / saturation, and contiguous buffer writes.
module accumulator_writeback #(
    parameter int LANES  = 32,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 16,
    parameter int ACC_AW = 7,
    parameter int UB_AW  = 12,
    parameter int RD_LAT = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              start_i,
    input  logic [ACC_AW:0]                   num_rows_i,
    input  logic [ACC_AW-1:0]                 acc_base_i,
    input  logic [UB_AW-1:0]                  ub_base_i,
    input  logic [4:0]                        shift_i,
    input  logic                              relu_en_i,
    input  logic                              hold_i,
    output logic                              acc_rd_en_o,
    output logic [ACC_AW-1:0]                 acc_addr_rd_o,
    input  logic [LANES-1:0][ACC_W-1:0]       acc_data_i,
    output logic                              ub_write_o,
    output logic [UB_AW-1:0]                  ub_addr_wr_o,
    output logic [LANES-1:0][OUT_W-1:0]       ub_data_o,
    output logic                              busy_o,
    output logic                              done_o
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    localparam int SAT_MAX = (1 << (OUT_W - 1)) - 1;
    localparam logic signed [ACC_W:0] SAT_HI = (ACC_W + 1)'(SAT_MAX);
    localparam logic signed [ACC_W:0] SAT_LO = (ACC_W + 1)'(-SAT_MAX - 1);

    state_t state;
    state_t state_nxt;

    logic [ACC_AW:0]                 num_q;
    logic [ACC_AW:0]                 cnt_q;
    logic [ACC_AW-1:0]               acc_base_q;
    logic [UB_AW-1:0]                wr_ptr;
    logic [4:0]                      shift_q;
    logic                            relu_q;
    logic [RD_LAT-1:0]               vld_pipe;
    logic                            rd_fire;
    logic                            cmd_go;
    logic                            row_arrive;
    logic [LANES-1:0][OUT_W-1:0]     row_proc;

    // ReLU, round-half-up arithmetic shift in ACC_W+1 bits, then clamp
    function automatic logic [OUT_W-1:0] lane_fn(
        input logic signed [ACC_W-1:0] x,
        input logic [4:0]              sh,
        input logic                    relu
    );
        logic signed [ACC_W:0] v;
        logic signed [ACC_W:0] rnd;
        v = {x[ACC_W-1], x};
        if (relu && x[ACC_W-1]) begin
            v = '0;
        end
        if (sh != 5'd0) begin
            rnd = (ACC_W + 1)'(1) << (sh - 5'd1);
            v   = v + rnd;
            v   = v >>> sh;
        end
        if (v > SAT_HI) begin
            v = SAT_HI;
        end else if (v < SAT_LO) begin
            v = SAT_LO;
        end
        return v[OUT_W-1:0];
    endfunction

    always_comb begin
        state_nxt = state;
        rd_fire   = 1'b0;
        cmd_go    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_i) begin
                    cmd_go    = 1'b1;
                    state_nxt = (num_rows_i == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (!hold_i) begin
                    rd_fire = 1'b1;
                    if ((cnt_q + 1'b1) == num_q) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (vld_pipe == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign acc_rd_en_o   = rd_fire;
    assign acc_addr_rd_o = acc_base_q + cnt_q[ACC_AW-1:0];
    assign busy_o        = (state == ISSUE) || (state == DRAIN);
    assign done_o        = (state == DONE);
    assign row_arrive    = vld_pipe[RD_LAT-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            num_q      <= '0;
            cnt_q      <= '0;
            acc_base_q <= '0;
            shift_q    <= '0;
            relu_q     <= 1'b0;
            vld_pipe   <= '0;
        end else begin
            state <= state_nxt;
            if (cmd_go) begin
                num_q      <= num_rows_i;
                cnt_q      <= '0;
                acc_base_q <= acc_base_i;
                shift_q    <= shift_i;
                relu_q     <= relu_en_i;
            end else if (rd_fire) begin
                cnt_q <= cnt_q + 1'b1;
            end
            // Read-latency tracker; returning rows are never stalled
            vld_pipe[0] <= rd_fire;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
        end
    end

    always_comb begin
        row_proc = '0;
        for (int l = 0; l < LANES; l++) begin
            row_proc[l] = lane_fn(acc_data_i[l], shift_q, relu_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ub_write_o   <= 1'b0;
            ub_addr_wr_o <= '0;
            ub_data_o    <= '0;
            wr_ptr       <= '0;
        end else begin
            ub_write_o <= row_arrive;
            if (row_arrive) begin
                ub_addr_wr_o <= wr_ptr;
                ub_data_o    <= row_proc;
                wr_ptr       <= wr_ptr + 1'b1;
            end else if (cmd_go) begin
                wr_ptr <= ub_base_i;
            end
        end
    end

endmodule

// File: tb/tb_accumulator_writeback.sv
// Randomized bench for accumulator_writeback with a queue-based
// reference model of reads, lane arithmetic and buffer writes.
module tb_accumulator_writeback;

    localparam int LANES = 32;

    logic                    clk = 1'b0;
    logic                    rst_i = 1'b1;
    logic                    start_i = 1'b0;
    logic [7:0]              num_rows_i = '0;
    logic [6:0]              acc_base_i = '0;
    logic [11:0]             ub_base_i = '0;
    logic [4:0]              shift_i = '0;
    logic                    relu_en_i = 1'b0;
    logic                    hold_i = 1'b0;
    logic                    acc_rd_en_o;
    logic [6:0]              acc_addr_rd_o;
    logic [LANES-1:0][31:0]  acc_data_i = '0;
    logic                    ub_write_o;
    logic [11:0]             ub_addr_wr_o;
    logic [LANES-1:0][15:0]  ub_data_o;
    logic                    busy_o;
    logic                    done_o;

    accumulator_writeback dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .num_rows_i   (num_rows_i),
        .acc_base_i   (acc_base_i),
        .ub_base_i    (ub_base_i),
        .shift_i      (shift_i),
        .relu_en_i    (relu_en_i),
        .hold_i       (hold_i),
        .acc_rd_en_o  (acc_rd_en_o),
        .acc_addr_rd_o(acc_addr_rd_o),
        .acc_data_i   (acc_data_i),
        .ub_write_o   (ub_write_o),
        .ub_addr_wr_o (ub_addr_wr_o),
        .ub_data_o    (ub_data_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0]  a;
        logic [511:0] d;
    } wexp_t;

    logic [1023:0] mem [128];
    int            cyc = 0;
    int            n_chk = 0;
    int            n_fail = 0;
    int            reads_seen, nwr, busy_cnt;
    int            first_wr_cyc, last_wr_cyc;
    logic [6:0]    rd_q [$];
    int            rdcyc_q [$];
    wexp_t         wr_q [$];

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] ref_lane(input logic [31:0] raw,
                                             input int sh, input bit relu);
        longint x;
        x = longint'($signed(raw));
        if (relu && x < 0) x = 0;
        if (sh > 0) x = (x + (longint'(1) <<< (sh - 1))) >>> sh;
        if (x > 32767) x = 32767;
        if (x < -32768) x = -32768;
        return 16'(x);
    endfunction

    function automatic logic [31:0] rand_word();
        int r;
        r = $urandom_range(0, 5);
        case (r)
            0: return $urandom;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 200000)) - 32'd100000;
            4: return 32'($urandom_range(0, 70000));
            default: return -32'($urandom_range(0, 70000));
        endcase
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (acc_rd_en_o) acc_data_i <= mem[acc_addr_rd_o];
        else acc_data_i <= {32{32'hDEAD_BEEF}};
    end

    // Scoreboard: read addresses, write address/data and read-to-write latency
    always @(negedge clk) begin
        if (acc_rd_en_o) begin
            chk("rd_expected", 512'(rd_q.size() > 0), 512'(1));
            if (rd_q.size() > 0) chk("rd_addr", 512'(acc_addr_rd_o),
                                     512'(rd_q.pop_front()));
            rdcyc_q.push_back(cyc);
            reads_seen++;
        end
        if (ub_write_o) begin
            chk("wr_expected", 512'(wr_q.size() > 0), 512'(1));
            if (wr_q.size() > 0) begin
                wexp_t e;
                e = wr_q.pop_front();
                chk("wr_addr", 512'(ub_addr_wr_o), 512'(e.a));
                chk("wr_data", ub_data_o, e.d);
            end
            if (rdcyc_q.size() > 0)
                chk("wr_latency", 512'(cyc), 512'(rdcyc_q.pop_front() + 2));
            nwr++;
            if (nwr == 1) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
        end
        if (busy_o) busy_cnt++;
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_rd_en"}, 512'(acc_rd_en_o), 512'(0));
        chk({tag, "_rd_addr"}, 512'(acc_addr_rd_o), 512'(0));
        chk({tag, "_ub_wr"}, 512'(ub_write_o), 512'(0));
        chk({tag, "_ub_addr"}, 512'(ub_addr_wr_o), 512'(0));
        chk({tag, "_ub_data"}, ub_data_o, 512'(0));
        chk({tag, "_busy"}, 512'(busy_o), 512'(0));
        chk({tag, "_done"}, 512'(done_o), 512'(0));
    endtask

    // mode: 0 plain, 1 random hold, 2 three-cycle hold after 2nd read,
    // 3 stray start while busy, 4 reset after 2nd read
    task automatic run(input int num, input int abase, input int ubase,
                       input int sh, input bit relu, input int mode);
        int s, done_cyc, held;
        bit fin, inj, rst_done;
        fin = 0; inj = 0; rst_done = 0; held = 0; done_cyc = -1;
        reads_seen = 0; nwr = 0; busy_cnt = 0;
        first_wr_cyc = -1; last_wr_cyc = -1;
        for (int k = 0; k < num; k++) begin
            wexp_t e;
            logic [1023:0] row;
            int ra;
            ra = (abase + k) % 128;
            rd_q.push_back(7'(ra));
            row = mem[ra];
            e.a = 12'((ubase + k) % 4096);
            for (int l = 0; l < LANES; l++)
                e.d[l*16 +: 16] = ref_lane(row[l*32 +: 32], sh, relu);
            wr_q.push_back(e);
        end
        @(posedge clk); #1;
        start_i = 1; num_rows_i = 8'(num); acc_base_i = 7'(abase);
        ub_base_i = 12'(ubase); shift_i = 5'(sh); relu_en_i = relu;
        s = cyc;
        for (int i = 0; i < 600 && !fin; i++) begin
            @(negedge clk);
            if (done_o) begin
                fin = 1;
                done_cyc = cyc;
            end else begin
                @(posedge clk); #1;
                start_i = 0;
                num_rows_i = 8'($urandom_range(0, 128));
                acc_base_i = 7'($urandom); ub_base_i = 12'($urandom);
                hold_i = 0;
                if (mode == 1) hold_i = ($urandom_range(0, 3) == 0);
                if (mode == 2 && reads_seen == 2 && held < 3) begin
                    hold_i = 1;
                    held++;
                end
                if (mode == 3 && reads_seen == 1 && !inj) begin
                    start_i = 1;
                    inj = 1;
                end
                if (mode == 4 && reads_seen == 2) begin
                    rst_i = 1;
                    @(posedge clk); #1;
                    rst_i = 0;
                    rd_q.delete(); rdcyc_q.delete(); wr_q.delete();
                    @(negedge clk);
                    check_all_zero("post_rst");
                    repeat (12) @(negedge clk);
                    chk("rst_write_count", 512'(nwr), 512'(1));
                    fin = 1;
                    rst_done = 1;
                end
            end
        end
        start_i = 0; hold_i = 0;
        if (!rst_done) begin
            chk("done_seen", 512'(fin), 512'(1));
            chk("wr_count", 512'(nwr), 512'(num));
            chk("rd_count", 512'(reads_seen), 512'(num));
            chk("done_cyc", 512'(done_cyc),
                512'(num == 0 ? s + 1 : last_wr_cyc + 1));
            chk("busy_cycles", 512'(busy_cnt), 512'(done_cyc - s - 1));
            if (mode == 2)
                chk("hold_gap", 512'(last_wr_cyc - first_wr_cyc), 512'(num + 2));
            @(negedge clk);
            chk("done_pulse", 512'(done_o), 512'(0));
        end
    endtask

    initial begin
        logic [31:0] pat [4];
        for (int r = 0; r < 128; r++)
            for (int l = 0; l < LANES; l++)
                mem[r][l*32 +: 32] = rand_word();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_i = 0;

        for (int r = 0; r < 4; r++)
            for (int l = 0; l < LANES; l++) mem[r][l*32 +: 32] = 32'd5;
        run(4, 0, 'h100, 0, 0, 0);
        chk("t1_lane0", 512'(ub_data_o[0]), 512'(5));

        pat[0] = 32'h18; pat[1] = -32'sd8;
        pat[2] = 32'h7FFF_FFFF; pat[3] = 32'h8000_0000;
        for (int l = 0; l < LANES; l++) mem[10][l*32 +: 32] = pat[l % 4];
        run(1, 10, 'h20, 4, 0, 0);
        chk("t2_l0", 512'(ub_data_o[0]), 512'(2));
        chk("t2_l1", 512'(ub_data_o[1]), 512'(0));
        chk("t2_l2", 512'(ub_data_o[2]), 512'(16'h7FFF));
        chk("t2_l3", 512'(ub_data_o[3]), 512'(16'h8000));
        run(1, 10, 'h20, 4, 1, 0);
        chk("t2r_l0", 512'(ub_data_o[0]), 512'(2));
        chk("t2r_l2", 512'(ub_data_o[2]), 512'(16'h7FFF));
        chk("t2r_l3", 512'(ub_data_o[3]), 512'(0));

        run(3, 126, 'hFFF, 3, 0, 0);
        run(5, 20, 'h40, 2, 0, 2);
        run(0, 5, 'h10, 0, 0, 0);
        run(8, 30, 'h200, 1, 1, 4);
        run(6, 40, 'h300, 7, 0, 0);
        run(4, 50, 'h310, 0, 1, 3);
        run(1, 127, 'hFFF, 31, 0, 0);
        run(128, 64, 'hFC0, 8, 0, 0);

        for (int t = 0; t < 30; t++) begin
            int n;
            n = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
            run(n, $urandom_range(0, 127), $urandom_range(0, 4095),
                $urandom_range(0, 31), 1'($urandom), $urandom_range(0, 1));
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
